// File: rtl/seg7_scan_driver.sv
// Multiplexed BCD seven-segment scan driver with a shadow register, frame-aligned
// display updates, leading-zero blanking and configurable output polarity.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 1000,
   parameter bit          SEG_ACTIVE_LOW = 1'b0,
   parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    ack
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BUS_W = 4 * NUM_DIGITS;

   localparam logic [6:0]            SEG_MASK = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_MASK = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [BUS_W-1:0]      r_shadow;
   logic [BUS_W-1:0]      r_disp;
   logic                  r_pending;
   logic                  r_ack;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_dig;

   logic                  w_tick;
   logic                  w_frame;
   logic [NUM_DIGITS:0]   w_hi_zero;
   logic [3:0]            w_cur;
   logic                  w_cur_lz;
   logic                  w_blank;
   logic [6:0]            w_seg_int;
   logic [NUM_DIGITS-1:0] w_dig_int;

   // Active-high segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles show a dash.
   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = 7'b1111110;
         4'd1:    pat = 7'b0110000;
         4'd2:    pat = 7'b1101101;
         4'd3:    pat = 7'b1111001;
         4'd4:    pat = 7'b0110011;
         4'd5:    pat = 7'b1011011;
         4'd6:    pat = 7'b1011111;
         4'd7:    pat = 7'b1110000;
         4'd8:    pat = 7'b1111111;
         4'd9:    pat = 7'b1111011;
         default: pat = 7'b0000001;
      endcase
      return pat;
   endfunction

   assign w_tick  = en && (r_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_frame = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

   // w_hi_zero[k] is set when nibbles k..NUM_DIGITS-1 of the displayed value are all zero.
   always_comb begin
      w_hi_zero             = '0;
      w_hi_zero[NUM_DIGITS] = 1'b1;
      w_cur                 = 4'd0;
      w_cur_lz              = 1'b0;
      w_dig_int             = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_hi_zero[k] = w_hi_zero[k+1] && (r_disp[4*k +: 4] == 4'd0);
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_cur        = r_disp[4*k +: 4];
            w_cur_lz     = w_hi_zero[k];
            w_dig_int[k] = 1'b1;
         end
      end
   end

   assign w_blank   = blank_lz && (r_idx != IDX_W'(0)) && w_cur_lz;
   assign w_seg_int = w_blank ? 7'd0 : f_decode(w_cur);

   // Scan counters, shadow/display handoff at the frame boundary, registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shadow  <= '0;
         r_disp    <= '0;
         r_pending <= 1'b0;
         r_ack     <= 1'b0;
         r_seg     <= SEG_MASK;
         r_dig     <= DIG_MASK;
      end else begin
         if (en) begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
         end
         if (w_tick) begin
            r_idx <= w_frame ? '0 : r_idx + IDX_W'(1);
         end
         if (load) begin
            r_shadow <= bcd_in;
         end
         if (w_frame && r_pending) begin
            r_disp <= r_shadow;
         end
         // A load coinciding with the boundary stays pending for the next frame.
         if (load) begin
            r_pending <= 1'b1;
         end else if (w_frame) begin
            r_pending <= 1'b0;
         end
         r_ack <= w_frame && r_pending;
         r_seg <= (en ? w_seg_int : 7'd0) ^ SEG_MASK;
         r_dig <= (en ? w_dig_int : '0) ^ DIG_MASK;
      end
   end

   assign seg     = r_seg;
   assign dig_sel = r_dig;
   assign ack     = r_ack;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, 4-cycle scan),
// with a second instance using active-low segments.
module tb_seg7_scan_driver;

   localparam logic [6:0] S0   = 7'b1111110;
   localparam logic [6:0] S1   = 7'b0110000;
   localparam logic [6:0] S2   = 7'b1101101;
   localparam logic [6:0] S3   = 7'b1111001;
   localparam logic [6:0] S4   = 7'b0110011;
   localparam logic [6:0] S5   = 7'b1011011;
   localparam logic [6:0] S7   = 7'b1110000;
   localparam logic [6:0] S9   = 7'b1111011;
   localparam logic [6:0] DASH = 7'b0000001;
   localparam logic [6:0] BLK  = 7'b0000000;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        en       = 1'b0;
   logic        load     = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] bcd_in   = 16'h0000;

   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic        ack;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   logic        ack_n;

   int errors  = 0;
   int checks  = 0;
   int ack_cnt = 0;

   seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
      .blank_lz(blank_lz), .seg(seg), .dig_sel(dig_sel), .ack(ack)
   );

   seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
      .blank_lz(blank_lz), .seg(seg_n), .dig_sel(dig_n), .ack(ack_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (ack === 1'b1) ack_cnt++;
   endtask

   task automatic do_load(input logic [15:0] v);
      bcd_in = v;
      load   = 1'b1;
      cyc();
      load   = 1'b0;
   endtask

   task automatic wait_ack(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (ack === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic sync0(input string tag);
      logic [3:0] prev;
      bit found = 1'b0;
      prev = dig_sel;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (dig_sel === 4'b0001 && prev !== 4'b0001) begin
            found = 1'b1;
            break;
         end
         prev = dig_sel;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   // Called on the first cycle of digit 0; checks a whole 16-cycle frame.
   task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] e [4];
      logic [6:0] inv;
      logic [3:0] exp_dig;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int j = 0; j < 16; j++) begin
         exp_dig = 4'(1 << (j / 4));
         inv     = ~e[j/4];
         chk($sformatf("%s_j%0d_dig", tag, j), 32'(dig_sel), 32'(exp_dig));
         chk($sformatf("%s_j%0d_seg", tag, j), 32'(seg), 32'(e[j/4]));
         chk($sformatf("%s_j%0d_segn", tag, j), 32'(seg_n), 32'(inv));
         chk($sformatf("%s_j%0d_dign", tag, j), 32'(dig_n), 32'(exp_dig));
         cyc();
      end
   endtask

   initial begin
      // Reset held for three cycles
      rst_n = 1'b0;
      en    = 1'b1;
      repeat (3) cyc();
      chk("rst_seg", 32'(seg), 32'(BLK));
      chk("rst_dig", 32'(dig_sel), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_segn", 32'(seg_n), 32'h7F);

      // Release: digit 0 shows "0", upper digits blanked
      rst_n    = 1'b1;
      blank_lz = 1'b1;
      cyc();
      chk("rel_dig", 32'(dig_sel), 32'd1);
      chk("rel_seg", 32'(seg), 32'(S0));
      check_frame("rel", S0, BLK, BLK, BLK);

      // Mid-frame load of 0x1234
      blank_lz = 1'b0;
      repeat (5) cyc();
      ack_cnt = 0;
      do_load(16'h1234);
      wait_ack("ack_1234");
      chk("ack_wrap_dig", 32'(dig_sel), 32'h8);
      chk("ack_old_seg", 32'(seg), 32'(S0));
      cyc();
      check_frame("v1234", S4, S3, S2, S1);
      chk("ack_once_1234", 32'(ack_cnt), 32'd1);

      // Leading-zero blanking
      blank_lz = 1'b1;
      do_load(16'h0070);
      wait_ack("ack_0070");
      cyc();
      check_frame("v0070", S0, S7, BLK, BLK);
      do_load(16'h0000);
      wait_ack("ack_0000");
      cyc();
      check_frame("v0000", S0, BLK, BLK, BLK);
      blank_lz = 1'b0;
      check_frame("v0000_nolz", S0, S0, S0, S0);

      // Invalid nibble counts as nonzero
      blank_lz = 1'b1;
      do_load(16'h00A5);
      wait_ack("ack_00a5");
      cyc();
      check_frame("v00a5", S5, DASH, BLK, BLK);

      // Two loads in one frame: last wins, single ack
      ack_cnt = 0;
      do_load(16'h1111);
      cyc();
      cyc();
      do_load(16'h2222);
      wait_ack("ack_2222");
      cyc();
      check_frame("v2222", S2, S2, S2, S2);
      chk("ack_once_2222", 32'(ack_cnt), 32'd1);

      // Load on the wrap cycle is deferred one frame
      ack_cnt = 0;
      repeat (14) cyc();
      do_load(16'h0009);
      chk("wrap_dig", 32'(dig_sel), 32'h8);
      chk("wrap_no_ack", 32'(ack), 32'd0);
      cyc();
      check_frame("wrap_old", S2, S2, S2, S2);
      chk("wrap_ack_later", 32'(ack_cnt), 32'd1);
      check_frame("wrap_new", S9, BLK, BLK, BLK);

      // Reset mid-frame with a pending load
      do_load(16'h0042);
      cyc();
      cyc();
      rst_n = 1'b0;
      cyc();
      cyc();
      chk("rst2_seg", 32'(seg), 32'(BLK));
      chk("rst2_dig", 32'(dig_sel), 32'd0);
      chk("rst2_ack", 32'(ack), 32'd0);
      chk("rst2_segn", 32'(seg_n), 32'h7F);
      ack_cnt = 0;
      rst_n   = 1'b1;
      cyc();
      chk("rel2_dig", 32'(dig_sel), 32'd1);
      chk("rel2_seg", 32'(seg), 32'(S0));
      check_frame("rel2_a", S0, BLK, BLK, BLK);
      check_frame("rel2_b", S0, BLK, BLK, BLK);
      chk("rst2_no_ack", 32'(ack_cnt), 32'd0);

      // Enable low for 10 cycles: outputs off, scan position held
      repeat (5) cyc();
      chk("pre_en_dig", 32'(dig_sel), 32'h2);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("en0_%0d_dig", i), 32'(dig_sel), 32'd0);
         chk($sformatf("en0_%0d_seg", i), 32'(seg), 32'(BLK));
         chk($sformatf("en0_%0d_segn", i), 32'(seg_n), 32'h7F);
      end
      en = 1'b1;
      cyc();
      chk("resume_j6", 32'(dig_sel), 32'h2);
      cyc();
      chk("resume_j7", 32'(dig_sel), 32'h2);
      cyc();
      chk("resume_j8", 32'(dig_sel), 32'h4);
      sync0("resume_sync");
      check_frame("resume", S0, BLK, BLK, BLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
